// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width : width of the slice counter for a WIDTH/DIGIT split
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // clog2 of the number of slices, never narrower than one bit so the
    // single-slice configuration still has a legal counter.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder.
//   start, sub, a, b, cin : operation request (driven by the master)
//   busy, done, s, cout, ovf : status and registered result (driven by the slave)
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder.
//   a, b, ci : addend bits and carry in
//   s, co    : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit ripple-carry adder built from full_adder cells.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of the top bit
//   c_top : carry into the top bit (used for the signed overflow flag)
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_top
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_fa
            full_adder u_fa (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (c[gi]),
                .s  (sum[gi]),
                .co (c[gi+1])
            );
        end
    endgenerate

    assign cout  = c[DIGIT];
    assign c_top = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per cycle, LSB slice first.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : request/result bundle (slave side), see serial_adder_if
// Subtraction is a + ~b + 1. Results load into s/cout/ovf only on the last
// slice, so they never show partial sums.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int             N    = WIDTH / DIGIT;
    localparam int             CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic [WIDTH-1:0]  a_reg, b_reg, s_reg;
    logic              carry_reg, cout_reg, ovf_reg;
    logic              busy, done, last_slice;

    logic [DIGIT-1:0]  dig_sum;
    logic              dig_cout, dig_ctop;
    logic [WIDTH-1:0]  sum_sh_next;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_reg[DIGIT-1:0]),
        .b     (b_reg[DIGIT-1:0]),
        .cin   (carry_reg),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_top (dig_ctop)
    );

    // Result shift register: each new slice enters at the top, so after N
    // shifts slice 0 sits at the bottom. Only the upper WIDTH-DIGIT bits need
    // storage; the newest slice comes straight from the adder.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign sum_sh_next = dig_sum;
        end else begin : g_shift
            logic [WIDTH-DIGIT-1:0] acc_reg;

            assign sum_sh_next = {dig_sum, acc_reg};

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (busy) begin
                    acc_reg <= sum_sh_next[WIDTH-1:DIGIT];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        last_slice = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_reg == LAST) begin
                    last_slice = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub ? 1'b1 : bus.cin;
                        cnt_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    carry_reg <= dig_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_slice) begin
                        s_reg    <= sum_sh_next;
                        cout_reg <= dig_cout;
                        ovf_reg  <= dig_ctop ^ dig_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.s    = s_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule
